// File: rtl/add_result_accum.sv
// ---------------------------------------------------------------------------
// add_result_accum
//
// Multi-sample summing stage placed directly after the 4-bit ripple-carry
// adder. Each accepted adder result {carry_in, sum_in} (0..31) is added into
// an ACC_W-bit accumulator. After N_SAMPLES results the total is offered to
// the consumer through a valid/ready handshake.
//
// Build option:
//   ADD_RESULT_ACCUM_SAT_EN  defined   -> accumulator saturates to all-ones
//                                         when an add carries out
//                            undefined -> accumulator wraps modulo 2^ACC_W
//   In both builds ovf is sticky for the current batch.
//
// Parameters:
//   ACC_W      accumulator / output width (5..16)
//   N_SAMPLES  adder results summed per output (1..15)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   clear       synchronous abort back to IDLE (beats every handshake)
//   in_valid    adder result valid
//   in_ready    block can accept a result
//   sum_in      adder sum S[3:0]
//   carry_in    adder carry-out Co
//   out_valid   accumulated total valid
//   out_ready   consumer accepts the total
//   acc_out     live accumulator (meaningful when out_valid=1)
//   ovf         sticky overflow for the current batch
//   sample_cnt  results accepted in the current batch
//
// State table:
//   state | meaning
//   IDLE  | empty batch, acc/cnt/ovf are zero, waiting for first result
//   ACCUM | 1..N_SAMPLES-1 results accepted, summing
//   HOLD  | batch complete, total offered, upstream stalled
// ---------------------------------------------------------------------------
module add_result_accum #(
    parameter int ACC_W     = 8,
    parameter int N_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum_in,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf,
    output logic [3:0]       sample_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        HOLD  = 2'b10
    } state_t;

    localparam logic [3:0] N_LAST = 4'(N_SAMPLES);

    state_t           state;
    state_t           state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] acc_add;
    logic [ACC_W:0]   sum_ext;
    logic [3:0]       cnt;
    logic [3:0]       cnt_nxt;
    logic [3:0]       cnt_inc;
    logic             ovf_q;
    logic             ovf_nxt;
    logic             out_valid_q;
    logic             alive;
    logic [4:0]       in_val;
    logic             accept;

    // alive keeps in_ready low while reset is held and for the release
    // cycle; it goes high on the first clock edge after rst_n rises.
    assign in_ready = alive & (state != HOLD);
    assign accept   = in_valid & in_ready;
    assign in_val   = {carry_in, sum_in};
    assign cnt_inc  = cnt + 4'd1;

    // One extra bit catches the carry out of the accumulator.
    assign sum_ext  = {1'b0, acc} + (ACC_W+1)'(in_val);

`ifdef ADD_RESULT_ACCUM_SAT_EN
    assign acc_add  = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_add  = sum_ext[ACC_W-1:0];
`endif

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf_q;
        if (clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_nxt   = '0;
            ovf_nxt   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_nxt   = ACC_W'(in_val);
                        cnt_nxt   = 4'd1;
                        ovf_nxt   = 1'b0;
                        state_nxt = (N_SAMPLES == 1) ? HOLD : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_nxt = acc_add;
                        cnt_nxt = cnt_inc;
                        ovf_nxt = ovf_q | sum_ext[ACC_W];
                        if (cnt_inc == N_LAST) begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        ovf_nxt   = 1'b0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            alive       <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            ovf_q       <= ovf_nxt;
            out_valid_q <= (state_nxt == HOLD);
            alive       <= 1'b1;
        end
    end

    assign out_valid  = out_valid_q;
    assign acc_out    = acc;
    assign ovf        = ovf_q;
    assign sample_cnt = cnt;

endmodule

// File: tb/tb_add_result_accum.sv
module tb_add_result_accum;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic [3:0] sum_in;
    logic       carry_in;
    logic       out_ready;

    logic       in_ready_a, out_valid_a, ovf_a;
    logic [7:0] acc_a;
    logic [3:0] cnt_a;

    logic       in_ready_b, out_valid_b, ovf_b;
    logic [5:0] acc_b;
    logic [3:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int acc_a;
        int ovf_a;
        int acc_b;
        int ovf_b;
    } exp_t;

    exp_t sb[$];

    add_result_accum #(.ACC_W(8), .N_SAMPLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_a),
        .sum_in(sum_in), .carry_in(carry_in),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .acc_out(acc_a), .ovf(ovf_a), .sample_cnt(cnt_a)
    );

    add_result_accum #(.ACC_W(6), .N_SAMPLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_b),
        .sum_in(sum_in), .carry_in(carry_in),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .acc_out(acc_b), .ovf(ovf_b), .sample_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference batch sum for a given width, independent of any RTL structure.
    function automatic void model(input int w, input int v0, input int v1,
                                  input int v2, input int v3,
                                  output int acc, output int of);
        int vals[4];
        int s;
        int lim;
        vals = '{v0, v1, v2, v3};
        lim  = 1 << w;
        acc  = 0;
        of   = 0;
        for (int i = 0; i < 4; i++) begin
            s = acc + vals[i];
            if (s >= lim) begin
                of = 1;
`ifdef ADD_RESULT_ACCUM_SAT_EN
                acc = lim - 1;
`else
                acc = s - lim;
`endif
            end else begin
                acc = s;
            end
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input int v);
        int t;
        t = 0;
        in_valid = 1'b1;
        {carry_in, sum_in} = 5'(v);
        while (!in_ready_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("send_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic send_batch(input int v0, input int v1, input int v2, input int v3);
        exp_t e;
        model(8, v0, v1, v2, v3, e.acc_a, e.ovf_a);
        model(6, v0, v1, v2, v3, e.acc_b, e.ovf_b);
        sb.push_back(e);
        send(v0);
        send(v1);
        send(v2);
        send(v3);
    endtask

    task automatic wait_out(input string tag);
        int t;
        exp_t e;
        t = 0;
        while (!out_valid_a && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_out_valid_a"}, 32'(out_valid_a), 32'd1);
        check({tag, "_out_valid_b"}, 32'(out_valid_b), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, "_acc_a"}, 32'(acc_a), 32'(e.acc_a));
            check({tag, "_ovf_a"}, 32'(ovf_a), 32'(e.ovf_a));
            check({tag, "_acc_b"}, 32'(acc_b), 32'(e.acc_b));
            check({tag, "_ovf_b"}, 32'(ovf_b), 32'(e.ovf_b));
            check({tag, "_cnt_a"}, 32'(cnt_a), 32'd4);
            check({tag, "_cnt_b"}, 32'(cnt_b), 32'd4);
            check({tag, "_in_ready"}, 32'(in_ready_a), 32'd0);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready_a"}, 32'(in_ready_a), 32'd1);
        check({tag, "_in_ready_b"}, 32'(in_ready_b), 32'd1);
        check({tag, "_out_valid"},  32'(out_valid_a), 32'd0);
        check({tag, "_acc_a"},      32'(acc_a), 32'd0);
        check({tag, "_acc_b"},      32'(acc_b), 32'd0);
        check({tag, "_cnt"},        32'(cnt_a), 32'd0);
        check({tag, "_ovf"},        32'(ovf_a), 32'd0);
    endtask

    initial begin
        int held_acc;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        sum_in    = 4'd0;
        carry_in  = 1'b0;
        out_ready = 1'b1;

        // Reset held
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_acc", 32'(acc_a), 32'd0);
        rst_n = 1'b1;

        // Idle for 10 cycles after release
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle("idle");
        end

        // Mixed batch: 3,7,16,31 -> 57, then one-cycle HOLD
        send_batch(3, 7, 16, 31);
        wait_out("mixed");
        {carry_in, sum_in} = 5'd1;
        @(negedge clk);
        check("post_hs_out_valid", 32'(out_valid_a), 32'd0);
        check("post_hs_acc", 32'(acc_a), 32'd0);
        check("post_hs_in_ready", 32'(in_ready_a), 32'd1);
        @(negedge clk);
        check("next_accept_acc", 32'(acc_a), 32'd1);
        check("next_accept_cnt", 32'(cnt_a), 32'd1);
        in_valid = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check_idle("clear1");

        // Overflow: 31 x4 -> 124 (8-bit), 60 wrap / 63 sat with ovf (6-bit)
        send_batch(31, 31, 31, 31);
        wait_out("ovf");
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("ovf_done");

        // Backpressure: HOLD for 5 cycles with in_valid high
        out_ready = 1'b0;
        send_batch(5, 5, 5, 5);
        wait_out("bp");
        held_acc = 20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready_a), 32'd0);
            check("bp_out_valid", 32'(out_valid_a), 32'd1);
            check("bp_acc", 32'(acc_a), 32'(held_acc));
            check("bp_cnt", 32'(cnt_a), 32'd4);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check_idle("bp_release");

        // clear with coincident in_valid after 2 samples
        send(6);
        send(6);
        check("pre_clear_acc", 32'(acc_a), 32'd12);
        check("pre_clear_cnt", 32'(cnt_a), 32'd2);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        check_idle("clear2");
        send_batch(1, 1, 1, 1);
        wait_out("after_clear");
        in_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset while in HOLD
        out_ready = 1'b0;
        send_batch(2, 2, 2, 2);
        wait_out("pre_rst");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid_a), 32'd0);
        check("async_rst_acc", 32'(acc_a), 32'd0);
        check("async_rst_cnt", 32'(cnt_a), 32'd0);
        check("async_rst_in_ready", 32'(in_ready_a), 32'd0);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_idle("rst_release");
        send_batch(9, 9, 9, 9);
        wait_out("resume");
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("final");
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
